// File: rtl/gaxi_beat_packer_if.sv
// Narrow-in / wide-out beat bus for gaxi_beat_packer.
// master = producer of narrow beats and consumer of wide beats; slave = the packer.
interface gaxi_beat_packer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int RATIO      = 4,
  parameter int OUT_WIDTH  = DATA_WIDTH * RATIO
);
  logic                  wr_valid;
  logic                  wr_ready;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_last;
  logic                  rd_valid;
  logic                  rd_ready;
  logic [OUT_WIDTH-1:0]  rd_data;
  logic [RATIO-1:0]      rd_strb;
  logic                  rd_last;
  logic [3:0]            count;

  modport slave (
    input  wr_valid, wr_data, wr_last, rd_ready,
    output wr_ready, rd_valid, rd_data, rd_strb, rd_last, count
  );

  modport master (
    output wr_valid, wr_data, wr_last, rd_ready,
    input  wr_ready, rd_valid, rd_data, rd_strb, rd_last, count
  );
endinterface

// File: rtl/gaxi_beat_packer.sv
// Packs RATIO narrow beats into one wide beat. Lane 0 sits at the LSBs;
// wr_last closes a wide beat early with the unfilled lanes zeroed.
// One accumulator plus one output register; wr_ready only looks at the
// output register and rd_ready, so a full beat can be replaced in the same
// cycle it is read.

// One accumulator lane: holds its narrow word and strobe until the wide beat
// closes, and presents the merged view (incoming word if this lane is the
// current write target) to the output register.
module gaxi_beat_packer_lane #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sel,
  input  logic                  clr,
  input  logic [DATA_WIDTH-1:0] d,
  output logic [DATA_WIDTH-1:0] mq,
  output logic                  mstrb
);
  logic [DATA_WIDTH-1:0] q;
  logic                  strb;

  // Capture the lane on a write aimed at it; a closing beat clears it.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q    <= '0;
      strb <= 1'b0;
    end else if (sel) begin
      q    <= d;
      strb <= 1'b1;
    end
  end

  assign mq    = sel ? d : q;
  assign mstrb = sel | strb;
endmodule

module gaxi_beat_packer #(
  parameter int DATA_WIDTH = 32,
  parameter int RATIO      = 4,
  parameter int OUT_WIDTH  = DATA_WIDTH * RATIO
) (
  input  logic              axi_aclk,
  input  logic              axi_areset,
  gaxi_beat_packer_if.slave bus
);
  logic [3:0]                       idx;
  logic                             wr_ready;
  logic                             wr_fire;
  logic                             rd_fire;
  logic                             complete;
  logic [RATIO-1:0]                 sel;
  logic [RATIO-1:0][DATA_WIDTH-1:0] mdata;
  logic [RATIO-1:0]                 mstrb;
  logic [OUT_WIDTH-1:0]             rd_data_q;
  logic [RATIO-1:0]                 rd_strb_q;
  logic                             rd_last_q;
  logic                             rd_valid_q;

  // Output slot is free when empty or being drained this cycle.
  assign wr_ready = ~rd_valid_q | bus.rd_ready;
  assign wr_fire  = bus.wr_valid & wr_ready;
  assign rd_fire  = rd_valid_q & bus.rd_ready;
  assign complete = wr_fire & ((idx == 4'(RATIO - 1)) | bus.wr_last);

  for (genvar i = 0; i < RATIO; i++) begin : g_lane
    assign sel[i] = wr_fire & (idx == 4'(i));
    gaxi_beat_packer_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
      .clk   (axi_aclk),
      .rst   (axi_areset),
      .sel   (sel[i]),
      .clr   (complete),
      .d     (bus.wr_data),
      .mq    (mdata[i]),
      .mstrb (mstrb[i])
    );
  end

  // Lane index and output register: a closing write reloads the output
  // (even while the old beat is being read), otherwise a read empties it.
  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      idx        <= '0;
      rd_data_q  <= '0;
      rd_strb_q  <= '0;
      rd_last_q  <= 1'b0;
      rd_valid_q <= 1'b0;
    end else if (complete) begin
      idx        <= '0;
      rd_data_q  <= mdata;
      rd_strb_q  <= mstrb;
      rd_last_q  <= bus.wr_last;
      rd_valid_q <= 1'b1;
    end else begin
      if (wr_fire) idx <= idx + 4'd1;
      if (rd_fire) rd_valid_q <= 1'b0;
    end
  end

  assign bus.wr_ready = wr_ready;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_strb  = rd_strb_q;
  assign bus.rd_last  = rd_last_q;
  assign bus.count    = idx;
endmodule
